// File: rtl/seg_mux_scheduler.sv
// Two-digit multiplexed 7-segment scheduler: cycles A/B with dead time between
// digits and swaps in newly loaded hex values only at a frame boundary.
module seg_mux_scheduler #(
    parameter int DWELL = 2500,
    parameter int BLANK = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] hex_a,
    input  logic [3:0] hex_b,
    output logic       load_ack,
    output logic [3:0] digit,
    output logic [1:0] anode
);

    localparam int MAX_LEN = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_BLANK_BA = 2'd0,
        ST_SHOW_A   = 2'd1,
        ST_BLANK_AB = 2'd2,
        ST_SHOW_B   = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] len_last_s;
    logic          last_s;
    logic          xfer_s;
    logic [3:0]    stg_a_r;
    logic [3:0]    stg_b_r;
    logic [3:0]    act_a_r;
    logic [3:0]    act_b_r;
    logic          pending_r;

    // Next-state selection and length of the current state.
    always_comb begin
        state_nxt_s = state_r;
        len_last_s  = BLANK_LAST;
        case (state_r)
            ST_BLANK_BA: begin
                len_last_s  = BLANK_LAST;
                state_nxt_s = ST_SHOW_A;
            end
            ST_SHOW_A: begin
                len_last_s  = DWELL_LAST;
                state_nxt_s = ST_BLANK_AB;
            end
            ST_BLANK_AB: begin
                len_last_s  = BLANK_LAST;
                state_nxt_s = ST_SHOW_B;
            end
            ST_SHOW_B: begin
                len_last_s  = DWELL_LAST;
                state_nxt_s = ST_BLANK_BA;
            end
            default: begin
                len_last_s  = BLANK_LAST;
                state_nxt_s = ST_BLANK_BA;
            end
        endcase
    end

    assign last_s = (cnt_r == len_last_s);
    // Staged pair moves to the display only on the edge leaving BLANK_BA.
    assign xfer_s = pending_r && (state_r == ST_BLANK_BA) && last_s;

    // State register and dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BLANK_BA;
            cnt_r   <= '0;
        end else if (last_s) begin
            state_r <= state_nxt_s;
            cnt_r   <= '0;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    // Staging, pending flag and frame-aligned transfer to the active pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_a_r   <= 4'h0;
            stg_b_r   <= 4'h0;
            act_a_r   <= 4'h0;
            act_b_r   <= 4'h0;
            pending_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                act_a_r <= stg_a_r;
                act_b_r <= stg_b_r;
            end else begin
                act_a_r <= act_a_r;
                act_b_r <= act_b_r;
            end
            // A load coinciding with a transfer keeps pending for the next frame.
            if (load) begin
                stg_a_r   <= hex_a;
                stg_b_r   <= hex_b;
                pending_r <= 1'b1;
            end else if (xfer_s) begin
                stg_a_r   <= stg_a_r;
                stg_b_r   <= stg_b_r;
                pending_r <= 1'b0;
            end else begin
                stg_a_r   <= stg_a_r;
                stg_b_r   <= stg_b_r;
                pending_r <= pending_r;
            end
        end
    end

    // Moore decode of the registered state; blank states force digit to zero.
    always_comb begin
        anode = 2'b11;
        digit = 4'h0;
        case (state_r)
            ST_SHOW_A: begin
                anode = 2'b10;
                digit = act_a_r;
            end
            ST_SHOW_B: begin
                anode = 2'b01;
                digit = act_b_r;
            end
            ST_BLANK_BA, ST_BLANK_AB: begin
                anode = 2'b11;
                digit = 4'h0;
            end
            default: begin
                anode = 2'b11;
                digit = 4'h0;
            end
        endcase
    end

    assign load_ack = xfer_s;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Self-checking bench for seg_mux_scheduler: frame-phase reference model,
// directed scenarios with literal expectations, then randomized load/reset.
module tb_seg_mux_scheduler;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int FRAME = 2 * (D + B);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] hex_a = 4'h0;
    logic [3:0] hex_b = 4'h0;
    logic       load_ack;
    logic [3:0] digit;
    logic [1:0] anode;

    int total = 0;
    int bad   = 0;

    // Reference model: position in frame comes from cycles since reset.
    int       m_t = 0;
    logic     m_valid = 1'b0;
    logic [3:0] m_stg_a = 4'h0, m_stg_b = 4'h0, m_act_a = 4'h0, m_act_b = 4'h0;
    logic     m_pend = 1'b0;

    logic [3:0] obs_digit;
    logic [1:0] obs_anode;
    logic       obs_ack;
    int         ack_count;
    logic       saw_one;

    seg_mux_scheduler #(.DWELL(D), .BLANK(B)) dut (
        .clk(clk), .reset(reset), .load(load), .hex_a(hex_a), .hex_b(hex_b),
        .load_ack(load_ack), .digit(digit), .anode(anode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_anode(input int p);
        if (p < B)               return 2'b11;
        else if (p < B + D)      return 2'b10;
        else if (p < 2 * B + D)  return 2'b11;
        else                     return 2'b01;
    endfunction

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic r, input logic ld, input logic [3:0] a, input logic [3:0] b);
        int p;
        logic [1:0] ea;
        logic [3:0] ed;
        reset = r; load = ld; hex_a = a; hex_b = b;
        @(negedge clk);
        obs_digit = digit; obs_anode = anode; obs_ack = load_ack;
        chk("anode_not_00", int'(anode == 2'b00), 0);
        if (anode == 2'b11) chk("blank_digit_zero", int'(digit), 0);
        if (m_valid) begin
            p  = m_t % FRAME;
            ea = exp_anode(p);
            ed = (ea == 2'b10) ? m_act_a : (ea == 2'b01) ? m_act_b : 4'h0;
            chk("anode", int'(anode), int'(ea));
            chk("digit", int'(digit), int'(ed));
            chk("load_ack", int'(load_ack), int'(m_pend && (p == B - 1)));
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1; m_t = 0; m_pend = 1'b0;
            m_stg_a = 4'h0; m_stg_b = 4'h0; m_act_a = 4'h0; m_act_b = 4'h0;
        end else begin
            if (m_pend && (m_t % FRAME == B - 1)) begin
                m_act_a = m_stg_a; m_act_b = m_stg_b; m_pend = 1'b0;
            end
            if (ld) begin
                m_stg_a = a; m_stg_b = b; m_pend = 1'b1;
            end
            m_t++;
        end
        #1;
    endtask

    initial begin
        // Free-run and single load of (3,C) in cycle 3.
        cycle(1'b1, 1'b0, 4'h0, 4'h0);
        ack_count = 0;
        for (int c = 0; c < 26; c++) begin
            cycle(1'b0, c == 3, 4'h3, 4'hC);
            if (obs_ack) ack_count++;
            if (c == 0)  begin chk("lit_c0_anode", obs_anode, 2'b11); chk("lit_c0_ack", obs_ack, 0); end
            if (c == 2)  chk("lit_c2_anode", obs_anode, 2'b10);
            if (c == 8)  chk("lit_c8_anode", obs_anode, 2'b01);
            if (c == 11) chk("lit_c11_digit", obs_digit, 4'h0);
            if (c == 13) chk("lit_c13_ack", obs_ack, 1);
            if (c == 14) chk("lit_c14_digit", obs_digit, 4'h3);
            if (c == 20) chk("lit_c20_digit", obs_digit, 4'hC);
        end
        chk("lit_single_ack", ack_count, 1);

        // Two loads before a boundary: only the second pair is ever shown.
        cycle(1'b1, 1'b0, 4'h0, 4'h0);
        saw_one = 1'b0;
        for (int c = 0; c < 26; c++) begin
            cycle(1'b0, (c == 4) || (c == 9), (c == 4) ? 4'h1 : 4'h5, (c == 4) ? 4'h2 : 4'h6);
            if (obs_digit == 4'h1) saw_one = 1'b1;
            if (c == 15) chk("lit_last_load_a", obs_digit, 4'h5);
            if (c == 21) chk("lit_last_load_b", obs_digit, 4'h6);
        end
        chk("lit_value1_never", saw_one, 0);

        // Load in cycle 3, another in cycle 13 coinciding with the transfer.
        cycle(1'b1, 1'b0, 4'h0, 4'h0);
        for (int c = 0; c < 38; c++) begin
            cycle(1'b0, (c == 3) || (c == 13), (c == 3) ? 4'h7 : 4'h9, (c == 3) ? 4'h8 : 4'hA);
            if (c == 14) chk("lit_78_a", obs_digit, 4'h7);
            if (c == 20) chk("lit_78_b", obs_digit, 4'h8);
            if (c == 25) chk("lit_second_ack", obs_ack, 1);
            if (c == 26) chk("lit_9A_a", obs_digit, 4'h9);
            if (c == 32) chk("lit_9A_b", obs_digit, 4'hA);
        end

        // Reset mid-frame discards a pending load; load during reset is dropped.
        cycle(1'b1, 1'b0, 4'h0, 4'h0);
        for (int c = 0; c < 10; c++) cycle(1'b0, c == 5, 4'hF, 4'hE);
        cycle(1'b1, 1'b1, 4'hB, 4'hD);
        ack_count = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle(1'b0, 1'b0, 4'h0, 4'h0);
            if (obs_ack) ack_count++;
            if (c == 0) begin chk("lit_rst_anode", obs_anode, 2'b11); chk("lit_rst_digit", obs_digit, 4'h0); end
            if (c == 3) chk("lit_rst_showa_digit", obs_digit, 4'h0);
        end
        chk("lit_rst_no_ack", ack_count, 0);

        // Randomized loads and occasional resets against the model.
        for (int c = 0; c < 4000; c++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
